strobe_sequencer: RTL and testbench

//  Sequences one internal counter_with_strobe through a programmable table of DEPTH phase

---
 rtl/strobe_sequencer.sv | 120 ++++++++++++
 tb/tb_strobe_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/strobe_sequencer.sv
// strobe_sequencer: steps a strobe counter through a table of phase lengths, pulsing at each phase end
module counter_with_strobe #(
  parameter int WIDTH = 16,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] reset_value,
  output logic             strobe
);
  localparam int LW = LATENCY < 1 ? 1 : $clog2(LATENCY + 1);
  logic [WIDTH-1:0] cnt;
  logic [LW-1:0] hold;
  logic go;
  assign go = enable && hold == '0;
  assign strobe = go && cnt == WIDTH'(1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= reset_value;
      hold <= LW'(LATENCY);
    end else begin
      if (hold != '0) hold <= hold - 1'b1;
      if (go) cnt <= cnt == WIDTH'(1) ? reset_value : cnt - 1'b1;
    end
endmodule

module strobe_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LATENCY = 0,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic             busy,
  output logic [IW-1:0]    phase_idx,
  output logic             phase_strobe,
  output logic             done,
  output logic             cfg_err,
  output logic             fault
);
  localparam int LW = LATENCY < 1 ? 1 : $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [WIDTH-1:0] timer, cur_len, wdata;
  logic [LW-1:0] lat_cnt;
  logic loop_q, ctr_rst, ctr_en, ctr_strobe, last, addr_ok;
  assign cur_len = tbl[phase_idx];
  assign wdata = cfg_data < WIDTH'(2) ? WIDTH'(2) : cfg_data;
  assign last = phase_idx == IW'(DEPTH - 1);
  assign addr_ok = 32'(cfg_addr) < DEPTH;
  counter_with_strobe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) ctr (
    .clk(clk), .rst(ctr_rst), .enable(ctr_en), .reset_value(cur_len), .strobe(ctr_strobe)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      phase_idx <= '0;
      busy <= 1'b0;
      phase_strobe <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      fault <= 1'b0;
      loop_q <= 1'b0;
      timer <= '0;
      lat_cnt <= '0;
      ctr_rst <= 1'b1;
      ctr_en <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= WIDTH'(2);
    end else begin
      phase_strobe <= 1'b0;
      done <= 1'b0;
      cfg_err <= cfg_we && (state != IDLE || !addr_ok);
      if (cfg_we && state == IDLE && addr_ok) tbl[cfg_addr] <= wdata;
      if (state == IDLE) begin
        if (start && !stop) begin
          state <= ARM;
          busy <= 1'b1;
          phase_idx <= '0;
          loop_q <= loop;
          fault <= 1'b0;
          lat_cnt <= '0;
        end
      end else if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
        phase_idx <= '0;
        ctr_rst <= 1'b1;
        ctr_en <= 1'b0;
      end else if (state == ARM) begin
        ctr_rst <= 1'b0;
        if (lat_cnt == LW'(LATENCY)) begin
          state <= RUN;
          ctr_en <= 1'b1;
          timer <= '0;
        end else lat_cnt <= lat_cnt + 1'b1;
      end else begin
        // the timer is authoritative; the counter only has to agree with it
        if (ctr_strobe != (timer == cur_len - 1'b1)) fault <= 1'b1;
        if (timer == cur_len - 1'b1) begin
          phase_strobe <= 1'b1;
          ctr_en <= 1'b0;
          ctr_rst <= 1'b1;
          lat_cnt <= '0;
          state <= last && !loop_q ? IDLE : ARM;
          busy <= !(last && !loop_q);
          done <= last && !loop_q;
          phase_idx <= last ? '0 : phase_idx + 1'b1;
        end else timer <= timer + 1'b1;
      end
    end
endmodule

// File: tb/tb_strobe_sequencer.sv
// tb_strobe_sequencer: directed scenarios on three sequencer configurations sharing stimulus
module tb_strobe_sequencer;
  logic clk = 0, rst = 1, cfg_we = 0, start = 0, stop = 0, loop = 0;
  logic cfg_addr = 0;
  logic [1:0] addr3 = 0;
  logic [15:0] cfg_data = 0;
  logic a_busy, a_idx, a_ps, a_done, a_err, a_fault;
  logic b_busy, b_idx, b_ps, b_done, b_err, b_fault;
  logic c_busy, c_ps, c_done, c_err, c_fault;
  logic [1:0] c_idx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  strobe_sequencer #(.WIDTH(16), .DEPTH(2), .LATENCY(0)) d0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start),
    .stop(stop), .loop(loop), .busy(a_busy), .phase_idx(a_idx), .phase_strobe(a_ps), .done(a_done),
    .cfg_err(a_err), .fault(a_fault));
  strobe_sequencer #(.WIDTH(16), .DEPTH(2), .LATENCY(2)) d2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start),
    .stop(stop), .loop(loop), .busy(b_busy), .phase_idx(b_idx), .phase_strobe(b_ps), .done(b_done),
    .cfg_err(b_err), .fault(b_fault));
  strobe_sequencer #(.WIDTH(16), .DEPTH(3), .LATENCY(0)) d3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(addr3), .cfg_data(cfg_data), .start(start),
    .stop(stop), .loop(loop), .busy(c_busy), .phase_idx(c_idx), .phase_strobe(c_ps), .done(c_done),
    .cfg_err(c_err), .fault(c_fault));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cfg_we = 0; start = 0; stop = 0; loop = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic wr(input logic a, input logic [15:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic launch(input logic lp);
    start = 1; loop = lp;
    tick();
    start = 0; loop = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if ({a_busy, a_idx, a_ps, a_done, a_err, a_fault} !== 6'b0) begin errors++; $display("FAIL reset_d0 got %b exp 000000", {a_busy, a_idx, a_ps, a_done, a_err, a_fault}); end
    checks++; if ({b_busy, b_idx, b_ps, b_done, b_err, b_fault} !== 6'b0) begin errors++; $display("FAIL reset_d2 got %b exp 000000", {b_busy, b_idx, b_ps, b_done, b_err, b_fault}); end
    checks++; if ({c_busy, c_idx, c_ps, c_done, c_err, c_fault} !== 7'b0) begin errors++; $display("FAIL reset_d3 got %b exp 0000000", {c_busy, c_idx, c_ps, c_done, c_err, c_fault}); end
    rst = 0;
  endtask

  task automatic test_single();
    do_reset(); wr(0, 3); wr(1, 5); launch(0);
    for (int c = 1; c <= 14; c++) begin
      checks++; if (a_ps !== (c == 5 || c == 11)) begin errors++; $display("FAIL single_strobe c=%0d got %b exp %b", c, a_ps, c == 5 || c == 11); end
      checks++; if (a_done !== (c == 11)) begin errors++; $display("FAIL single_done c=%0d got %b exp %b", c, a_done, c == 11); end
      checks++; if (a_busy !== (c <= 10)) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, a_busy, c <= 10); end
      checks++; if (a_idx !== (c >= 5 && c <= 10)) begin errors++; $display("FAIL single_idx c=%0d got %b exp %b", c, a_idx, c >= 5 && c <= 10); end
      tick();
    end
    checks++; if (a_fault !== 1'b0) begin errors++; $display("FAIL single_fault got %b exp 0", a_fault); end
  endtask

  task automatic test_loop();
    do_reset(); wr(0, 3); wr(1, 5); launch(1);
    for (int c = 1; c <= 22; c++) begin
      logic es, ei;
      es = c >= 5 && ((c - 1) % 10 == 4 || (c - 1) % 10 == 0);
      ei = (c - 1) % 10 >= 4;
      checks++; if (a_ps !== es) begin errors++; $display("FAIL loop_strobe c=%0d got %b exp %b", c, a_ps, es); end
      checks++; if (a_idx !== ei) begin errors++; $display("FAIL loop_idx c=%0d got %b exp %b", c, a_idx, ei); end
      checks++; if (a_done !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL loop_done_busy c=%0d got %b%b exp 01", c, a_done, a_busy); end
      tick();
    end
    stop = 1; tick(); stop = 0;
    checks++; if ({a_busy, a_ps, a_done} !== 3'b0) begin errors++; $display("FAIL loop_stop got %b exp 000", {a_busy, a_ps, a_done}); end
    checks++; if (a_fault !== 1'b0) begin errors++; $display("FAIL loop_fault got %b exp 0", a_fault); end
  endtask

  task automatic test_latency();
    do_reset(); wr(0, 4); wr(1, 4); launch(0);
    for (int c = 1; c <= 16; c++) begin
      logic ee;
      ee = (c >= 4 && c <= 7) || (c >= 11 && c <= 14);
      checks++; if (b_ps !== (c == 8 || c == 15)) begin errors++; $display("FAIL lat_strobe c=%0d got %b exp %b", c, b_ps, c == 8 || c == 15); end
      checks++; if (b_done !== (c == 15)) begin errors++; $display("FAIL lat_done c=%0d got %b exp %b", c, b_done, c == 15); end
      checks++; if (d2.ctr_en !== ee) begin errors++; $display("FAIL lat_ctr_en c=%0d got %b exp %b", c, d2.ctr_en, ee); end
      tick();
    end
    checks++; if (b_fault !== 1'b0) begin errors++; $display("FAIL lat_fault got %b exp 0", b_fault); end
  endtask

  task automatic test_clamp_and_busy_write();
    do_reset(); wr(0, 0); wr(1, 1); launch(0);
    for (int c = 1; c <= 8; c++) begin
      checks++; if (a_ps !== (c == 4 || c == 7)) begin errors++; $display("FAIL clamp_strobe c=%0d got %b exp %b", c, a_ps, c == 4 || c == 7); end
      checks++; if (a_done !== (c == 7)) begin errors++; $display("FAIL clamp_done c=%0d got %b exp %b", c, a_done, c == 7); end
      checks++; if (a_err !== (c == 3)) begin errors++; $display("FAIL busy_write_err c=%0d got %b exp %b", c, a_err, c == 3); end
      cfg_we = c == 2; cfg_addr = 0; cfg_data = 9;
      tick();
    end
    cfg_we = 0;
    launch(0);
    for (int c = 1; c <= 8; c++) begin
      checks++; if (a_ps !== (c == 4 || c == 7)) begin errors++; $display("FAIL table_kept_strobe c=%0d got %b exp %b", c, a_ps, c == 4 || c == 7); end
      tick();
    end
    cfg_we = 1; cfg_addr = 0; cfg_data = 6; start = 1;
    tick();
    cfg_we = 0; start = 0;
    for (int c = 1; c <= 12; c++) begin
      checks++; if (a_ps !== (c == 8 || c == 11)) begin errors++; $display("FAIL write_start_strobe c=%0d got %b exp %b", c, a_ps, c == 8 || c == 11); end
      checks++; if (a_done !== (c == 11)) begin errors++; $display("FAIL write_start_done c=%0d got %b exp %b", c, a_done, c == 11); end
      tick();
    end
    checks++; if (a_fault !== 1'b0) begin errors++; $display("FAIL clamp_fault got %b exp 0", a_fault); end
  endtask

  task automatic test_bad_addr();
    do_reset();
    cfg_we = 1; addr3 = 3; cfg_data = 9;
    tick();
    cfg_we = 0;
    checks++; if (c_err !== 1'b1) begin errors++; $display("FAIL bad_addr_err got %b exp 1", c_err); end
    cfg_we = 1; addr3 = 2; cfg_data = 7;
    tick();
    cfg_we = 0;
    checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL good_addr_err got %b exp 0", c_err); end
    launch(0);
    for (int c = 1; c <= 16; c++) begin
      checks++; if (c_ps !== (c == 4 || c == 7 || c == 15)) begin errors++; $display("FAIL d3_strobe c=%0d got %b exp %b", c, c_ps, c == 4 || c == 7 || c == 15); end
      checks++; if (c_done !== (c == 15)) begin errors++; $display("FAIL d3_done c=%0d got %b exp %b", c, c_done, c == 15); end
      tick();
    end
  endtask

  task automatic test_stop();
    do_reset(); wr(0, 3); wr(1, 5); launch(0);
    for (int c = 1; c <= 12; c++) begin
      checks++; if (a_busy !== (c <= 7)) begin errors++; $display("FAIL stop_busy c=%0d got %b exp %b", c, a_busy, c <= 7); end
      checks++; if (a_ps !== (c == 5)) begin errors++; $display("FAIL stop_strobe c=%0d got %b exp %b", c, a_ps, c == 5); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL stop_done c=%0d got %b exp 0", c, a_done); end
      stop = c == 7;
      tick();
    end
    stop = 1; start = 1;
    tick();
    stop = 0; start = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy c=%0d got %b exp 0", c, a_busy); end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    do_reset(); wr(0, 3); wr(1, 5); launch(0);
    tick(); tick();
    rst = 1;
    tick();
    checks++; if ({a_busy, a_idx, a_ps, a_done, a_err, a_fault} !== 6'b0) begin errors++; $display("FAIL rst_mid got %b exp 000000", {a_busy, a_idx, a_ps, a_done, a_err, a_fault}); end
    rst = 0;
    launch(0);
    for (int c = 1; c <= 8; c++) begin
      checks++; if (a_ps !== (c == 4 || c == 7)) begin errors++; $display("FAIL rst_table_strobe c=%0d got %b exp %b", c, a_ps, c == 4 || c == 7); end
      checks++; if (a_done !== (c == 7)) begin errors++; $display("FAIL rst_table_done c=%0d got %b exp %b", c, a_done, c == 7); end
      tick();
    end
    checks++; if (a_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", a_fault); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_loop();
    test_latency();
    test_clamp_and_busy_write();
    test_bad_addr();
    test_stop();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
